uart_lfsr_tx_top: RTL and testbench

- Top-level FPGA block, clocked from the 12 MHz board oscillator.
- Generates a pseudo-random byte stream with an 8-bit LFSR and sends it continuously over a UART TX pin (8N1).
- Shows the low nibble of the byte in flight on four LEDs.
- Holds the configuration-flash SPI chip-select deasserted.

---
 rtl/uart_lfsr_tx_top.sv | 121 ++++++++++++
 tb/tb_uart_lfsr_tx_top.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lfsr_tx_top.sv
// rtl/uart_lfsr_tx_top.sv - LFSR byte generator streamed over an 8N1 UART transmitter
module uart_lfsr_tx_top #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] LFSR_SEED    = 8'h01
) (
    input  logic       osc_12m,
    input  logic       resetn,
    output logic       spi_cs,
    output logic [3:0] leds,
    output logic       tx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q, state_d;
    logic        tx_q, tx_d;
    logic [3:0]  leds_q, leds_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;

    logic        bit_end;
    logic        lfsr_fb;
    logic [7:0]  lfsr_next;

    // Flash must stay deselected so it never contends with the FPGA after configuration.
    assign spi_cs = 1'b1;
    assign leds   = leds_q;
    assign tx     = tx_q;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_next = {lfsr_q[6:0], lfsr_fb};

    // Next-state logic: tx_d is the line level for the current state, registered one cycle later.
    always_comb begin
        state_d    = state_q;
        tx_d       = 1'b1;
        leds_d     = leds_q;
        lfsr_d     = lfsr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        case (state_q)
            S_IDLE: begin
                // Capture the current LFSR value, then step it; a stuck-at-zero LFSR is reseeded.
                shift_d    = lfsr_q;
                leds_d     = lfsr_q[3:0];
                lfsr_d     = (lfsr_q == 8'h00) ? LFSR_SEED : lfsr_next;
                bit_cnt_d  = 3'd0;
                baud_cnt_d = 16'd0;
                tx_d       = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any frame in flight and returns the line to idle.
    always_ff @(posedge osc_12m) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            leds_q     <= 4'h0;
            lfsr_q     <= LFSR_SEED;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            leds_q     <= leds_d;
            lfsr_q     <= lfsr_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_lfsr_tx_top.sv
// tb/tb_uart_lfsr_tx_top.sv - scoreboard bench for uart_lfsr_tx_top
module tb_uart_lfsr_tx_top;

    localparam int CPB_A = 104;
    localparam int CPB_B = 2;

    logic       clk = 1'b0;
    logic       resetn_a = 1'b0;
    logic       resetn_b = 1'b0;
    logic       spi_a, spi_b, tx_a, tx_b;
    logic [3:0] leds_a, leds_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int spi_bad  = 0;

    logic [7:0] expq_a[$];
    logic [7:0] expq_b[$];
    logic [7:0] rx_b[$];

    logic [7:0] table_a[12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                                8'h47, 8'h8E, 8'h1C, 8'h38, 8'h71, 8'hE2};

    uart_lfsr_tx_top u_dut_a (
        .osc_12m(clk), .resetn(resetn_a), .spi_cs(spi_a), .leds(leds_a), .tx(tx_a)
    );

    uart_lfsr_tx_top #(.CLKS_PER_BIT(CPB_B), .LFSR_SEED(8'h01)) u_dut_b (
        .osc_12m(clk), .resetn(resetn_b), .spi_cs(spi_b), .leds(leds_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_a !== 1'b1 || spi_b !== 1'b1) spi_bad <= spi_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic tx_of(input int id);
        return (id == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic rst_of(input int id);
        return (id == 0) ? resetn_a : resetn_b;
    endfunction

    function automatic logic [3:0] leds_of(input int id);
        return (id == 0) ? leds_a : leds_b;
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? expq_a.size() : expq_b.size();
    endfunction

    // Decodes frames from the line and compares each byte against the expected queue.
    task automatic monitor(input int id, input int cpb);
        logic       prev = 1'b1;
        int         last_start = -1;
        logic [7:0] b;
        logic       start_v, stop_v, first_v, unstable, aborted, v;
        logic [7:0] exp;
        int         n;
        forever begin
            @(negedge clk);
            if (!rst_of(id)) begin
                prev = 1'b1;
                last_start = -1;
                continue;
            end
            if (prev && !tx_of(id)) begin
                if (last_start >= 0)
                    check($sformatf("frame_spacing%0d", id), cyc - last_start, 10 * cpb + 1);
                last_start = cyc;
                b = 8'h00; start_v = 1'b1; stop_v = 1'b0; first_v = 1'b0;
                unstable = 1'b0; aborted = 1'b0;
                for (int c = 0; c < 10 * cpb; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_of(id)) begin
                        aborted = 1'b1;
                        break;
                    end
                    v = tx_of(id);
                    n = c / cpb;
                    if (c % cpb == 0) first_v = v;
                    else if (v !== first_v) unstable = 1'b1;
                    if (c % cpb == cpb / 2) begin
                        if (n == 0) start_v = v;
                        else if (n <= 8) b[n - 1] = v;
                        else stop_v = v;
                    end
                end
                if (aborted) begin
                    prev = 1'b1;
                    last_start = -1;
                    continue;
                end
                check($sformatf("start_bit%0d", id), start_v, 1'b0);
                check($sformatf("stop_bit%0d", id), stop_v, 1'b1);
                check($sformatf("bit_stable%0d", id), unstable, 1'b0);
                check($sformatf("leds%0d", id), leds_of(id), b[3:0]);
                if (qsize(id) == 0) begin
                    n_checks++;
                    $display("FAIL frame_unexpected%0d: got %0h expected none", id, b);
                end else begin
                    exp = (id == 0) ? expq_a.pop_front() : expq_b.pop_front();
                    check($sformatf("byte%0d", id), b, exp);
                end
                if (id == 1) rx_b.push_back(b);
                prev = 1'b1;
            end else begin
                prev = tx_of(id);
            end
        end
    endtask

    task automatic wait_empty(input int id, input int bound, input string name);
        int k = 0;
        while (qsize(id) != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, qsize(id) == 0, 1'b1);
    endtask

    initial monitor(0, CPB_A);
    initial monitor(1, CPB_B);

    task automatic stim_a();
        logic prev;
        int   k;
        // Reset held for 10 cycles: line idle, LEDs dark.
        resetn_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_tx", tx_a, 1'b1);
            check("reset_leds", leds_a, 4'h0);
        end
        resetn_a = 1'b1;
        for (int i = 0; i < 12; i++) expq_a.push_back(table_a[i]);
        @(negedge clk);
        check("load_edge_tx", tx_a, 1'b1);
        check("load_edge_leds", leds_a, 4'h1);
        @(negedge clk);
        check("start_edge_tx", tx_a, 1'b0);
        wait_empty(0, 13 * 1041 + 200, "stream_done");

        // Fresh start, then reset during data bit 4 of frame 3.
        resetn_a = 1'b0;
        repeat (3) @(negedge clk);
        expq_a.delete();
        resetn_a = 1'b1;
        expq_a.push_back(8'h01);
        expq_a.push_back(8'h02);
        wait_empty(0, 3 * 1041 + 200, "pre_abort_done");
        prev = tx_a;
        k = 0;
        while (!(prev && !tx_a) && k < 3000) begin
            @(negedge clk);
            if (prev && !tx_a) break;
            prev = tx_a;
            k++;
        end
        check("frame3_found", k < 3000, 1'b1);
        repeat (5 * CPB_A + CPB_A / 2) @(negedge clk);
        resetn_a = 1'b0;
        @(negedge clk);
        check("abort_tx", tx_a, 1'b1);
        check("abort_leds", leds_a, 4'h0);
        repeat (3) @(negedge clk);
        expq_a.delete();
        resetn_a = 1'b1;
        for (int i = 0; i < 3; i++) expq_a.push_back(table_a[i]);
        wait_empty(0, 4 * 1041 + 200, "post_abort_done");
        resetn_a = 1'b0;
    endtask

    task automatic stim_b();
        logic [7:0] v;
        logic       seen[256];
        int         dup, zero;
        resetn_b = 1'b0;
        repeat (3) @(negedge clk);
        resetn_b = 1'b1;
        v = 8'h01;
        for (int i = 0; i < 256; i++) begin
            expq_b.push_back(v);
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        wait_empty(1, 256 * 21 + 200, "period_done");
        resetn_b = 1'b0;
        check("period_count", rx_b.size() >= 256, 1'b1);
        if (rx_b.size() >= 256) begin
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            dup = 0;
            zero = 0;
            for (int i = 0; i < 255; i++) begin
                if (seen[rx_b[i]]) dup++;
                seen[rx_b[i]] = 1'b1;
                if (rx_b[i] == 8'h00) zero++;
            end
            check("period_256th", rx_b[255], 8'h01);
            check("period_dups", dup, 0);
            check("period_zero", zero, 0);
        end
    endtask

    initial begin
        fork
            stim_a();
            stim_b();
        join
        repeat (5) @(negedge clk);
        check("spi_cs_never_low", spi_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
